// File: rtl/pwm_dac_multi_if.sv
// Duty-source bus for pwm_dac_multi: register request/ack and per-channel sample stream.
interface pwm_dac_multi_if #(
    parameter int WIDTH    = 12,
    parameter int CHANNELS = 2
);
    logic [CHANNELS-1:0]       mode;
    logic [CHANNELS*WIDTH-1:0] reg_duty;
    logic                      reg_req;
    logic                      reg_ack;
    logic [CHANNELS-1:0]       s_valid;
    logic [CHANNELS*WIDTH-1:0] s_data;
    logic [CHANNELS-1:0]       s_ready;

    modport master (
        output mode, reg_duty, reg_req, s_valid, s_data,
        input  reg_ack, s_ready
    );

    modport slave (
        input  mode, reg_duty, reg_req, s_valid, s_data,
        output reg_ack, s_ready
    );
endinterface

// File: rtl/pwm_dac_multi.sv
// Multi-channel PWM DAC; duty updates commit only at the period boundary.
// Define PWM_PHASE_STAGGER_EN to spread channel counters evenly across the period.
module pwm_dac_multi #(
    parameter int WIDTH    = 12,
    parameter int CHANNELS = 2,
    parameter int PRESCALE = 1
) (
    input  logic                clk,
    input  logic                rst,
    pwm_dac_multi_if.slave      bus,
    input  logic                underflow_clr,
    output logic [CHANNELS-1:0] underflow,
    output logic                period_start,
    output logic [CHANNELS-1:0] pwm
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    logic [PW-1:0]    psc;
    logic [WIDTH-1:0] cnt;
    logic             tick;
    logic             boundary;
    logic             pending;
    logic             reg_ack_q;
    logic [WIDTH-1:0] act    [CHANNELS];
    logic [WIDTH-1:0] shadow [CHANNELS];
    logic [WIDTH-1:0] cnt_c  [CHANNELS];

    assign tick        = (psc == PMAX);
    assign boundary    = tick && (cnt == '1);
    assign bus.reg_ack = reg_ack_q;
    assign bus.s_ready = boundary ? bus.mode : '0;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_phase
`ifdef PWM_PHASE_STAGGER_EN
        localparam logic [WIDTH-1:0] OFS = WIDTH'((2 ** WIDTH / CHANNELS) * c);
        assign cnt_c[c] = cnt + OFS;
`else
        assign cnt_c[c] = cnt;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psc          <= '0;
            cnt          <= '0;
            pending      <= 1'b0;
            reg_ack_q    <= 1'b0;
            period_start <= 1'b0;
            underflow    <= '0;
            pwm          <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                act[c]    <= '0;
                shadow[c] <= '0;
            end
        end else begin
            psc <= tick ? '0 : psc + 1'b1;
            if (tick) begin
                cnt <= cnt + 1'b1;
            end
            reg_ack_q    <= boundary && pending;
            period_start <= boundary;
            for (int c = 0; c < CHANNELS; c++) begin
                pwm[c] <= (cnt_c[c] < act[c]);
            end
            // Clear first so a same-cycle underflow set takes priority.
            if (underflow_clr) begin
                underflow <= '0;
            end
            if (boundary) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    if (bus.mode[c]) begin
                        if (bus.s_valid[c]) begin
                            act[c] <= bus.s_data[c*WIDTH +: WIDTH];
                        end else begin
                            underflow[c] <= 1'b1;
                        end
                    end else if (pending) begin
                        act[c] <= shadow[c];
                    end
                end
            end
            // Requests seen while pending are dropped, not queued.
            if (boundary && pending) begin
                pending <= 1'b0;
            end else if (bus.reg_req && !pending) begin
                pending <= 1'b1;
                for (int c = 0; c < CHANNELS; c++) begin
                    shadow[c] <= bus.reg_duty[c*WIDTH +: WIDTH];
                end
            end
        end
    end
endmodule

// File: doc/pwm_dac_multi.md
# pwm_dac_multi

Multi-channel PWM DAC that generalises the single-channel audio `dac` block. It supports a parametrised duty-cycle width, channel count and counter prescaler. Each channel takes its duty cycle either from a CPU-written register bank or from a sample stream fed by an `async_fifo` read port. All duty updates are committed only at a period boundary, so output pulses never glitch. It sits in the `pwm_clk_g` domain between the FIFO/CPU request path and the per-channel output IOB flops.

## Interface

Parameters:
- `WIDTH`, 12: duty-cycle and counter width in bits; the period is 2^WIDTH ticks.
- `CHANNELS`, 2: number of independent PWM outputs (≥1; must be a power of two when `PWM_PHASE_STAGGER_EN` is defined).
- `PRESCALE`, 1: `clk` cycles per counter tick (≥1).

Ports:
- `clk`  in  1: single clock; the block uses one clock, and every flop is on its rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `mode`  in  CHANNELS: per-channel source select; 0 = register, 1 = stream.
- `reg_duty`  in  CHANNELS*WIDTH: register-source duty values; channel c occupies bits [c*WIDTH +: WIDTH].
- `reg_req`  in  1: request to load `reg_duty`.
- `reg_ack`  out  1: one-cycle pulse when a captured register update has been committed.
- `s_valid`  in  CHANNELS: per-channel stream sample valid.
- `s_data`  in  CHANNELS*WIDTH: per-channel stream samples.
- `s_ready`  out  CHANNELS: per-channel sample consume strobe.
- `underflow`  out  CHANNELS: sticky flag; a stream channel had no sample at a boundary.
- `underflow_clr`  in  1: clears all `underflow` bits.
- `period_start`  out  1: one-cycle pulse in the cycle after a commit.
- `pwm`  out  CHANNELS: registered PWM outputs.

## Operation

- The prescaler counts 0..PRESCALE-1. `tick` is high when the prescaler equals PRESCALE-1; with PRESCALE=1, `tick` is always high.
- The shared counter `cnt` (WIDTH bits) increments on `tick` and wraps from 2^WIDTH-1 to 0.
- `boundary` = `tick` && `cnt` == 2^WIDTH-1. All commits happen in the boundary cycle.
- Each channel holds an active duty register `act[c]`. The output is `pwm[c]` <= (`cnt_c` < `act[c]`). Without staggering, `cnt_c` = `cnt`.
- Duty range:
  - 0 gives an output that is constantly low.
  - 2^WIDTH-1 gives an output that is high for 2^WIDTH-1 of every 2^WIDTH ticks.
  - Full-on (100 %) is not representable.
- Register path:
  - If `reg_req`=1 and `pending`=0, capture all of `reg_duty` into `shadow` and set `pending`.
  - A `reg_req` that arrives while `pending`=1 is ignored and is not queued.
  - At `boundary` with `pending`=1: `act[c]` <= `shadow[c]` for every channel with `mode[c]`=0; clear `pending`; pulse `reg_ack` in the next cycle.
  - If `reg_req` arrives in the boundary cycle with `pending`=0, it is captured and committed at the following boundary.
- Stream path:
  - `s_ready[c]` = `boundary` && `mode[c]`. It is a function of state only and never depends on `s_valid`.
  - At `boundary` with `s_valid[c]`=1, `act[c]` <= `s_data[c]`.
  - At `boundary` with `s_valid[c]`=0, `act[c]` holds its value and `underflow[c]` is set.
- If `underflow_clr` and a new underflow occur in the same cycle, the set wins.
- Changing `mode[c]` takes effect only at the next boundary. The old `act[c]` value is held until then.
- When `rst` is asserted mid-period, all state clears immediately. The counter restarts from 0 on release, and any `pending` request is discarded without an ack.

## Timing

- Reset values:
  - `pwm`=0, `reg_ack`=0, `s_ready`=0, `underflow`=0, `period_start`=0.
  - Internal: `cnt`=0, prescaler=0, `act`=0, `shadow`=0, `pending`=0.
- `pwm` lags `cnt` by one cycle.
- A committed duty value first affects `pwm` in the cycle after `cnt` wraps to 0, i.e. 2 cycles after the boundary cycle.
- `reg_ack` and `period_start` are high for exactly one cycle, 1 cycle after the boundary.
- With PRESCALE=P, the period is P*2^WIDTH `clk` cycles. `s_ready` pulses at most once per period per channel.

## Configuration

- `PWM_PHASE_STAGGER_EN`:
  - Defined: `cnt_c` = (`cnt` + c*2^WIDTH/CHANNELS) mod 2^WIDTH, which spreads channel edges evenly across the period. Commits remain on the global boundary, so a channel with c>0 may emit one truncated or extended pulse on the period in which its duty changes.
  - Undefined: `cnt_c` = `cnt` for all channels, and all rising edges are aligned.

## Test plan

- **Reset:** WIDTH=4, CHANNELS=2, PRESCALE=1; hold `rst` for 5 cycles, then release -> all outputs 0; `period_start` first pulses at cycle 16 after release.
- **Register update:** `mode`=00, `reg_duty`={4'd12, 4'd3}, single-cycle `reg_req` -> exactly one `reg_ack` pulse at the next boundary+1; from then on ch0 is high 3 of every 16 cycles and ch1 is high 12 of every 16 cycles; a second `reg_req` issued while pending produces no second ack.
- **Stream underflow:** `mode`=11; `s_valid`=11 with ch0=8 and ch1=15; then drop `s_valid[1]` for one period -> `s_ready`=11 pulses once per 16 cycles; ch0 is high 8/16; ch1 holds 15/16 and `underflow`=10; `underflow_clr` returns it to 00.
- **Duty extremes:** duty 0 -> `pwm` never rises; duty 15 -> `pwm` is low for exactly 1 of every 16 cycles.
- **Prescale and reset mid-period:** PRESCALE=3 -> period is 48 cycles; assert `rst` at cycle 20 with `pending`=1 -> no `reg_ack`; the counter restarts from 0.
- **Stagger:** with `PWM_PHASE_STAGGER_EN` defined and both channels at duty 4 -> ch1 rises 8 cycles after ch0; with the macro undefined -> both rise in the same cycle.
